cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Memory-side responder for the cache controller's miss/fill interface. It accepts a read or write request from the controller (`mem_read`/`mem_write`, `mem_addr`, `mem_wdata`), waits a parameterised number of cycles to model backing-store latency, performs the access on an internal word-addressed RAM, and then answers with `mem_ready` and `mem_rdata` under a four-phase handshake. It sits between `cache_controller` and the backing store, on the opposite end of the link from the controller's `cache2mem_*` outputs and `mem2cache_*` inputs.

## Interface
- `ADDR_W`, default 32: byte-address width from the controller.
- `DATA_W`, default 32: word width.
- `DEPTH_W`, default 8: log2 of the RAM depth in words (256 words).
- `LATENCY`, default 3: wait cycles before a response; legal values are 1..15.

- `iCLK`: input, 1 bit. Single clock; all logic on the rising edge.
- `iRST`: input, 1 bit. Synchronous reset, active-high.
- `mem_read`: input, 1 bit. Read request; held high until `mem_ready` is seen.
- `mem_write`: input, 1 bit. Write request; same hold rule as `mem_read`.
- `mem_addr`: input, `ADDR_W` bits. Byte address; stable while a request is high.
- `mem_wdata`: input, `DATA_W` bits. Write data; stable while `mem_write` is high.
- `mem_rdata`: output, `DATA_W` bits. Read data; valid while `mem_ready` is high.
- `mem_ready`: output, 1 bit. Response; held until the request drops.
- `busy`: output, 1 bit. High in every state except IDLE.
- `mem_err`: output, 1 bit. Out-of-range flag; exists only with `MEM_RESP_ERR_EN`.

## Operation
- State machine with four states: IDLE, WAIT, DONE, RELEASE.
- **IDLE**
  - A request is `mem_read | mem_write`.
  - On a request: latch the address, write data and operation; load `cnt = LATENCY-1`; go to WAIT.
  - If both `mem_read` and `mem_write` are high, the operation is a write.
- **WAIT**
  - While `cnt != 0`: decrement `cnt`.
  - When `cnt == 0`: perform the access on the latched values.
    - Read: `mem_rdata <= ram[idx]`.
    - Write: `ram[idx] <= wdata` and `mem_rdata <= wdata` (write-through echo).
  - Then set `mem_ready = 1` and go to DONE.
- **DONE**
  - Hold `mem_ready = 1` and `mem_rdata`.
  - When the request input drops: clear `mem_ready` and go to RELEASE.
- **RELEASE**
  - Spend one turnaround cycle, then go to IDLE.
  - A request already high in RELEASE is not sampled until IDLE.
- Word index: `idx = mem_addr[DEPTH_W+1:2]`. Bits [1:0] are ignored.
- Inputs are latched on entry to WAIT. Changes to the inputs during WAIT or DONE are ignored; this is a protocol violation by the controller and is not checked.
- RAM contents are not affected by reset. RAM initial contents are all zero in simulation.

## Timing
- Request sampled high at edge t0 (IDLE):
  - `mem_ready` rises after edge t0+LATENCY.
  - Read data is visible in the same cycle as `mem_ready`.
- Request deasserted and sampled at edge t1 (DONE): `mem_ready` falls after t1.
- Earliest next request acceptance is edge t1+2.
- Minimum full transaction, assuming the request drops immediately: LATENCY+3 cycles.
- Reset values: `mem_ready = 0`, `mem_rdata = 0`, `busy = 0`, `mem_err = 0`, state IDLE, `cnt = 0`.
- `iRST` mid-transaction:
  - Abort to IDLE on the next edge with all outputs at their reset values.
  - A write whose WAIT has not reached `cnt == 0` is discarded.
  - A write already performed stays in the RAM.
- `busy` is registered; it rises the cycle after the request is accepted.

## Configuration
- Macro: `MEM_RESP_ERR_EN`.
- **Defined:**
  - The `mem_err` port exists.
  - An address counts as out-of-range if `mem_addr[ADDR_W-1:DEPTH_W+2]` is nonzero.
  - For an out-of-range address the access is suppressed: no RAM write, and `mem_rdata = 0`.
  - `mem_err` rises and falls together with `mem_ready` for that transaction.
- **Undefined:**
  - The `mem_err` port is absent.
  - Upper address bits are ignored, so addresses alias (wrap) modulo 2^(DEPTH_W+2) bytes.

## Test plan
- **Reset:** hold `iRST = 1` for 3 cycles -> all outputs 0 and `busy = 0`.
- **Write then read:** LATENCY=3, write `0xDEADBEEF` to `0x10`, then read `0x10` -> `mem_ready` 3 cycles after acceptance; `mem_rdata = 0xDEADBEEF`.
- **Handshake hold:** keep `mem_read` high 5 cycles past `mem_ready` -> `mem_ready` stays high 5 cycles, falls one cycle after `mem_read` drops, then one RELEASE cycle with `busy = 1`.
- **Simultaneous request and byte offset:** `mem_read = mem_write = 1`, addr `0x13`, data `0x5A5A5A5A` -> write to word 4; a later read of `0x10` returns `0x5A5A5A5A`.
- **Reset mid-WAIT:** LATENCY=4, write `0x1234` to `0x20`, assert `iRST` 2 cycles after acceptance -> `mem_ready` never rises; a read of `0x20` returns 0.
- **Out-of-range address:** `0x400` with DEPTH_W=8, after `0xCAFE` has been written to `0x0`.
  - Without `MEM_RESP_ERR_EN`: the read returns `0xCAFE` (wrap).
  - With `MEM_RESP_ERR_EN`: the read returns 0 with `mem_err = 1`.

Source files
------------

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: latency-modelling RAM responder for the cache miss/fill link; optional MEM_RESP_ERR_EN adds out-of-range error reporting
module cache_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 8,
    parameter int LATENCY = 3
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy
`ifdef MEM_RESP_ERR_EN
    ,
    output logic              mem_err
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;
    state_t               state;
    logic [3:0]           cnt;
    logic [DEPTH_W-1:0]   lat_idx;
    logic [DATA_W-1:0]    lat_wdata;
    logic                 lat_wr;
    logic                 lat_oor;
    logic                 addr_oor;
    logic                 req;
    logic                 ram_we;
    logic                 unused_addr;
    logic [DATA_W-1:0]    ram [0:(1<<DEPTH_W)-1];

    assign req    = mem_read | mem_write;
    assign ram_we = !iRST && state == WAIT && cnt == 4'd0 && lat_wr && !lat_oor;
`ifdef MEM_RESP_ERR_EN
    assign addr_oor    = |mem_addr[ADDR_W-1:DEPTH_W+2];
    assign unused_addr = ^mem_addr[1:0];
`else
    assign addr_oor    = 1'b0;
    assign unused_addr = ^{mem_addr[ADDR_W-1:DEPTH_W+2], mem_addr[1:0]};
`endif

    // Backing-store array: no reset so contents survive an aborted transaction
    always_ff @(posedge iCLK) begin
        if (ram_we)
            ram[lat_idx] <= lat_wdata;
    end

    // Request handshake FSM: latch on accept, count down latency, answer, wait for release
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            busy      <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            mem_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_idx   <= mem_addr[DEPTH_W+1:2];
                        lat_wdata <= mem_wdata;
                        lat_wr    <= mem_write;
                        lat_oor   <= addr_oor;
                        cnt       <= 4'(LATENCY - 1);
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mem_rdata <= lat_oor ? '0 : lat_wr ? lat_wdata : ram[lat_idx];
                        mem_ready <= 1'b1;
`ifdef MEM_RESP_ERR_EN
                        mem_err   <= lat_oor;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (!req) begin
                        mem_ready <= 1'b0;
`ifdef MEM_RESP_ERR_EN
                        mem_err   <= 1'b0;
`endif
                        state     <= RELEASE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: randomized self-checking bench against an array reference model
module tb_cache_mem_responder;
    localparam int LAT = 4;
    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        mem_err;
    logic [31:0] model [0:255];
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    always #5 iCLK = ~iCLK;

    cache_mem_responder #(.LATENCY(LAT)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy(busy)
`ifdef MEM_RESP_ERR_EN
        ,
        .mem_err(mem_err)
`endif
    );
`ifndef MEM_RESP_ERR_EN
    assign mem_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // One full transaction; entered and left #1 after a rising edge with the DUT idle
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data, input int hold);
        bit          oor;
        int          idx;
        int          n;
        logic [31:0] exp;
        oor = 1'b0;
`ifdef MEM_RESP_ERR_EN
        oor = addr >= 32'd1024;
`endif
        idx = int'((addr % 32'd1024) / 32'd4);
        exp = oor ? 32'd0 : wr ? data : model[idx];
        if (wr && !oor) model[idx] = data;
        mem_read = rd;
        mem_write = wr;
        mem_addr = addr;
        mem_wdata = data;
        tick();
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_noready", 32'(mem_ready), 32'd0);
        n = 0;
        while (!mem_ready && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, LAT);
        check("rdata", mem_rdata, exp);
        check("err", 32'(mem_err), 32'(oor));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_ready", 32'(mem_ready), 32'd1);
            check("hold_rdata", mem_rdata, exp);
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        tick();
        check("drop_ready", 32'(mem_ready), 32'd0);
        check("drop_err", 32'(mem_err), 32'd0);
        check("release_busy", 32'(busy), 32'd1);
        tick();
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int r;
        for (int i = 0; i < 256; i++) model[i] = '0;
        repeat (3) tick();
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        iRST = 1'b0;
        for (int i = 0; i < 256; i++) txn(1'b0, 1'b1, 32'(i * 4), 32'd0, 0);
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(1'b1, 1'b0, 32'h10, 32'd0, 5);
        txn(1'b1, 1'b1, 32'h13, 32'h5A5A5A5A, 1);
        txn(1'b1, 1'b0, 32'h10, 32'd0, 0);
        mem_write = 1'b1;
        mem_addr = 32'h20;
        mem_wdata = 32'h1234;
        tick();
        check("abort_accept", 32'(busy), 32'd1);
        tick();
        iRST = 1'b1;
        tick();
        check("abort_ready", 32'(mem_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdata", mem_rdata, 32'd0);
        mem_write = 1'b0;
        tick();
        iRST = 1'b0;
        tick();
        check("abort_idle_ready", 32'(mem_ready), 32'd0);
        txn(1'b1, 1'b0, 32'h20, 32'd0, 0);
        txn(1'b0, 1'b1, 32'h0, 32'hCAFE, 0);
        txn(1'b1, 1'b0, 32'h400, 32'd0, 0);
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 2));
            txn(r != 1, r != 0, 32'($urandom_range(0, 4095)), $urandom, int'($urandom_range(0, 3)));
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
